// File: rtl/servo_slew_ctrl.sv
// APB3-controlled two-axis servo pulse-width slew controller.
// Each axis ramps its current width toward a clamped target by STEP per PWM frame.
module servo_slew_ctrl #(
  parameter int unsigned MIN_W    = 40000,
  parameter int unsigned MAX_W    = 80000,
  parameter int unsigned CENTER_W = 60000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  input  logic        period_start,
  output logic [19:0] x_width,
  output logic [19:0] y_width,
  output logic        irq
);

  localparam int unsigned W   = 20;
  localparam int unsigned DW1 = W + 1;
  localparam int unsigned SW  = 16;
  localparam int unsigned BW  = 32;

  typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} axis_state_e;

  logic [W-1:0]  x_tgt, y_tgt, x_cur, y_cur;
  logic [SW-1:0] step;
  logic          enable, irq_en, irq_pending;

  logic [2:0]    addr;
  logic          wr_en, wr_ok;
  axis_state_e   x_state, y_state;
  logic          x_moving, y_moving, any_moving, upd;
  logic [W-1:0]  x_cur_nxt, y_cur_nxt;
  logic          irq_set, irq_clr, pending_nxt, irq_en_nxt;
  logic          unused_bits;

  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:W]};

  function automatic logic [W-1:0] clamp_w(input logic [W-1:0] v);
    if (v < W'(MIN_W))      return W'(MIN_W);
    else if (v > W'(MAX_W)) return W'(MAX_W);
    else                    return v;
  endfunction

  // One slew step toward target; signed difference is one bit wider so it never wraps.
  function automatic logic [W-1:0] slew(input logic [W-1:0] cur,
                                        input logic [W-1:0] tgt,
                                        input logic [SW-1:0] stp);
    logic signed [DW1-1:0] diff;
    logic [DW1-1:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DW1-1] ? DW1'(-diff) : DW1'(diff);
    if (stp == '0 || mag <= DW1'(stp)) return tgt;
    else if (diff[DW1-1])              return cur - W'(stp);
    else                               return cur + W'(stp);
  endfunction

  assign addr  = PADDR[4:2];
  assign wr_en = PSEL & PENABLE & PWRITE;
  assign wr_ok = wr_en & ~addr[2];

  assign x_state    = (x_cur != x_tgt) ? MOVING : IDLE;
  assign y_state    = (y_cur != y_tgt) ? MOVING : IDLE;
  assign x_moving   = (x_state == MOVING);
  assign y_moving   = (y_state == MOVING);
  assign any_moving = x_moving | y_moving;
  assign upd        = period_start & enable;

  // Slew uses the registered (old) targets, so a same-cycle target write waits a frame.
  assign x_cur_nxt = (upd && x_moving) ? slew(x_cur, x_tgt, step) : x_cur;
  assign y_cur_nxt = (upd && y_moving) ? slew(y_cur, y_tgt, step) : y_cur;

  assign irq_set     = upd & any_moving & (x_cur_nxt == x_tgt) & (y_cur_nxt == y_tgt);
  assign irq_clr     = wr_ok & (addr == 3'd3) & PWDATA[2];
  assign pending_nxt = irq_set | (irq_pending & ~irq_clr);
  assign irq_en_nxt  = (wr_ok && addr == 3'd3) ? PWDATA[1] : irq_en;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      x_tgt       <= W'(CENTER_W);
      y_tgt       <= W'(CENTER_W);
      x_cur       <= W'(CENTER_W);
      y_cur       <= W'(CENTER_W);
      step        <= '0;
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
    end else begin
      x_cur       <= x_cur_nxt;
      y_cur       <= y_cur_nxt;
      irq_pending <= pending_nxt;
      irq_en      <= irq_en_nxt;
      irq         <= pending_nxt & irq_en_nxt;
      if (wr_ok) begin
        case (addr)
          3'd0:    x_tgt  <= clamp_w(PWDATA[W-1:0]);
          3'd1:    y_tgt  <= clamp_w(PWDATA[W-1:0]);
          3'd2:    step   <= PWDATA[SW-1:0];
          3'd3:    enable <= PWDATA[0];
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux and error response.
  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (addr)
        3'd0:    PRDATA = BW'(x_tgt);
        3'd1:    PRDATA = BW'(y_tgt);
        3'd2:    PRDATA = BW'(step);
        3'd3:    PRDATA = BW'({irq_en, enable});
        3'd4:    PRDATA = BW'({irq_pending, y_moving, x_moving});
        3'd5:    PRDATA = BW'(x_cur);
        3'd6:    PRDATA = BW'(y_cur);
        default: PRDATA = '0;
      endcase
    end
  end

  assign PSLVERR = PSEL & PENABLE & (PWRITE ? addr[2] : (addr == 3'd7));
  assign PREADY  = 1'b1;
  assign x_width = x_cur;
  assign y_width = y_cur;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl: register table plus motion/irq sequences.
module tb_servo_slew_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        period_start;
  logic [19:0] x_width, y_width;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  servo_slew_ctrl dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .period_start(period_start), .x_width(x_width), .y_width(y_width), .irq(irq)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic wr, logic [2:0] a, logic [31:0] d,
                              logic chk_rd, logic [31:0] exp_rd, logic exp_err);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = a; v.data = d;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] a, input logic [31:0] d,
                     input logic ps, output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {27'd0, a, 2'b00}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; period_start = ps;
    #1;
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; period_start = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb(1'b1, a, d, 1'b0, rd, err);
  endtask

  task automatic wr_ps(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb(1'b1, a, d, 1'b1, rd, err);
  endtask

  task automatic rd_chk(string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb(1'b0, a, 32'd0, 1'b0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic strobe();
    @(posedge PCLK); #1; period_start = 1'b1;
    @(posedge PCLK); #1; period_start = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; period_start = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_x_width", 32'(x_width), 32'd60000);
    check("rst_y_width", 32'(y_width), 32'd60000);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    PRESERN = 1'b1;

    // Register access table
    add("rd_xcur",        1'b0, 3'd5, 32'd0,        1'b1, 32'd60000, 1'b0);
    add("rd_ycur",        1'b0, 3'd6, 32'd0,        1'b1, 32'd60000, 1'b0);
    add("rd_status0",     1'b0, 3'd4, 32'd0,        1'b1, 32'd0,     1'b0);
    add("rd_step0",       1'b0, 3'd2, 32'd0,        1'b1, 32'd0,     1'b0);
    add("wr_xtgt_lo",     1'b1, 3'd0, 32'd10,       1'b0, 32'd0,     1'b0);
    add("rd_xtgt_lo",     1'b0, 3'd0, 32'd0,        1'b1, 32'd40000, 1'b0);
    add("wr_xtgt_hi",     1'b1, 3'd0, 32'hFFFFF,    1'b0, 32'd0,     1'b0);
    add("rd_xtgt_hi",     1'b0, 3'd0, 32'd0,        1'b1, 32'd80000, 1'b0);
    add("wr_xtgt_ctr",    1'b1, 3'd0, 32'd60000,    1'b0, 32'd0,     1'b0);
    add("rd_xtgt_ctr",    1'b0, 3'd0, 32'd0,        1'b1, 32'd60000, 1'b0);
    add("wr_ytgt",        1'b1, 3'd1, 32'd50000,    1'b0, 32'd0,     1'b0);
    add("rd_ytgt",        1'b0, 3'd1, 32'd0,        1'b1, 32'd50000, 1'b0);
    add("wr_ytgt_ctr",    1'b1, 3'd1, 32'd60000,    1'b0, 32'd0,     1'b0);
    add("wr_status",      1'b1, 3'd4, 32'd7,        1'b0, 32'd0,     1'b1);
    add("rd_status_keep", 1'b0, 3'd4, 32'd0,        1'b1, 32'd0,     1'b0);
    add("wr_xcur",        1'b1, 3'd5, 32'd123,      1'b0, 32'd0,     1'b1);
    add("rd_xcur_keep",   1'b0, 3'd5, 32'd0,        1'b1, 32'd60000, 1'b0);
    add("wr_unmapped",    1'b1, 3'd7, 32'd5,        1'b0, 32'd0,     1'b1);
    add("rd_unmapped",    1'b0, 3'd7, 32'd0,        1'b1, 32'd0,     1'b1);
    add("wr_step",        1'b1, 3'd2, 32'hABCD1234, 1'b0, 32'd0,     1'b0);
    add("rd_step",        1'b0, 3'd2, 32'd0,        1'b1, 32'h1234,  1'b0);
    add("wr_ctrl",        1'b1, 3'd3, 32'd7,        1'b0, 32'd0,     1'b0);
    add("rd_ctrl",        1'b0, 3'd3, 32'd0,        1'b1, 32'd3,     1'b0);
    add("wr_ctrl0",       1'b1, 3'd3, 32'd0,        1'b0, 32'd0,     1'b0);
    add("wr_step0",       1'b1, 3'd2, 32'd0,        1'b0, 32'd0,     1'b0);
    add("rd_status_eq",   1'b0, 3'd4, 32'd0,        1'b1, 32'd0,     1'b0);

    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd, err);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) check(vecs[i].name, rd, vecs[i].exp_rd);
    end

    // Basic slew with completion flag, irq masked
    wr_reg(3'd2, 32'd1000);
    wr_reg(3'd3, 32'd1);
    wr_reg(3'd0, 32'd62500);
    rd_chk("slew_status_mov", 3'd4, 32'd1);
    check("slew_no_frame", 32'(x_width), 32'd60000);
    strobe(); check("slew_x1", 32'(x_width), 32'd61000);
    strobe(); check("slew_x2", 32'(x_width), 32'd62000);
    strobe(); check("slew_x3", 32'(x_width), 32'd62500);
    check("slew_y_hold", 32'(y_width), 32'd60000);
    rd_chk("slew_status_done", 3'd4, 32'd4);
    check("slew_irq_masked", 32'(irq), 32'd0);
    wr_reg(3'd3, 32'd5);
    rd_chk("slew_status_clr", 3'd4, 32'd0);

    // Clear coincident with completing update: set wins
    wr_reg(3'd3, 32'd3);
    wr_reg(3'd0, 32'd61000);
    strobe(); check("race_x1", 32'(x_width), 32'd61500);
    check("race_irq_pre", 32'(irq), 32'd0);
    wr_ps(3'd3, 32'd7);
    check("race_x2", 32'(x_width), 32'd61000);
    check("race_irq_set_wins", 32'(irq), 32'd1);
    rd_chk("race_status", 3'd4, 32'd4);
    wr_reg(3'd3, 32'd7);
    check("race_irq_cleared", 32'(irq), 32'd0);

    // Target write in the same cycle as a frame: old target still drives this step
    wr_reg(3'd0, 32'd64000);
    wr_ps(3'd0, 32'd58000);
    check("tgt_race_old", 32'(x_width), 32'd62000);
    strobe(); check("tgt_race_n1", 32'(x_width), 32'd61000);
    strobe(); check("tgt_race_n2", 32'(x_width), 32'd60000);
    strobe(); check("tgt_race_n3", 32'(x_width), 32'd59000);
    check("tgt_race_irq_mid", 32'(irq), 32'd0);
    strobe(); check("tgt_race_n4", 32'(x_width), 32'd58000);
    check("tgt_race_irq_end", 32'(irq), 32'd1);
    wr_reg(3'd3, 32'd7);

    // Disabled hold, then STEP=0 jumps directly to target
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd1, 32'd70000);
    strobe(); check("dis_y_hold", 32'(y_width), 32'd60000);
    rd_chk("dis_status", 3'd4, 32'd2);
    wr_reg(3'd3, 32'd1);
    strobe(); check("jump_y", 32'(y_width), 32'd70000);
    check("jump_x_hold", 32'(x_width), 32'd58000);
    rd_chk("jump_status", 3'd4, 32'd4);

    // Reset mid-motion abandons movement
    wr_reg(3'd3, 32'd5);
    wr_reg(3'd2, 32'd5000);
    wr_reg(3'd1, 32'd40000);
    strobe(); check("mid_y1", 32'(y_width), 32'd65000);
    #2; PRESERN = 1'b0;
    #1;
    check("mid_rst_y", 32'(y_width), 32'd60000);
    check("mid_rst_x", 32'(x_width), 32'd60000);
    check("mid_rst_irq", 32'(irq), 32'd0);
    @(posedge PCLK); #1; PRESERN = 1'b1;
    rd_chk("mid_status", 3'd4, 32'd0);
    rd_chk("mid_ytgt", 3'd1, 32'd60000);
    rd_chk("mid_step", 3'd2, 32'd0);
    rd_chk("mid_ctrl", 3'd3, 32'd0);
    strobe(); check("mid_y_idle", 32'(y_width), 32'd60000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
